// File: rtl/systolic_pkg.sv
// Shared types for the systolic MAC array: feeder state encoding and a
// counter-width helper used by the edge drivers.
package systolic_pkg;

  typedef enum logic [5:0] {
    IDLE_S  = 6'b000001,
    ARMED_S = 6'b000010,
    SKEW_S  = 6'b000100,
    ISSUE_S = 6'b001000,
    DRAIN_S = 6'b010000,
    DONE_S  = 6'b100000
  } feeder_state_e;

  // Bits needed to hold 0..max_val, never less than one.
  function automatic int cnt_w(input int max_val);
    cnt_w = (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/feeder_buf.sv
// Operand vector store: depth_p x width_p registers, one synchronous write
// port and one asynchronous read port. Contents are deliberately not reset.
module feeder_buf import systolic_pkg::*; #(
  parameter int width_p = 32,
  parameter int depth_p = 8,
  parameter int addr_w_p = $clog2(depth_p)
) (
  input  logic                clk_i,
  input  logic                we_i,
  input  logic [addr_w_p-1:0] waddr_i,
  input  logic [width_p-1:0]  wdata_i,
  input  logic [addr_w_p-1:0] raddr_i,
  output logic [width_p-1:0]  rdata_o
);

  logic [width_p-1:0] mem_q [depth_p];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/operand_feeder.sv
// Edge driver for one systolic row: loads an operand vector, streams it into
// the first PE after a programmable skew, and sinks the far-edge stream.
module operand_feeder import systolic_pkg::*; #(
  parameter int width_p = 32,
  parameter int depth_p = 8,
  parameter int skew_p  = 0
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               en_i,
  input  logic               ld_valid_i,
  output logic               ld_ready_o,
  input  logic [width_p-1:0] ld_data_i,
  input  logic               ld_last_i,
  input  logic               start_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               data_valid_o,
  input  logic               data_ready_i,
  output logic [width_p-1:0] data_o,
  input  logic               tail_valid_i,
  input  logic [width_p-1:0] tail_data_i,
  output logic               tail_yumi_o
);

  localparam int CW = cnt_w(depth_p);
  localparam int SW = cnt_w(skew_p);
  localparam int AW = $clog2(depth_p);

  feeder_state_e state_q, state_d;
  logic [CW-1:0] len_q, len_d;
  logic [CW-1:0] wr_cnt_q, wr_cnt_d;
  logic [CW-1:0] rd_cnt_q, rd_cnt_d;
  logic [CW-1:0] tail_cnt_q, tail_cnt_d;
  logic [SW-1:0] skew_cnt_q, skew_cnt_d;

  logic               ld_fire, iss_fire;
  logic [width_p-1:0] rdata;
  logic               unused_tail;

  // The far-edge words have already been consumed by every PE in the row.
  assign unused_tail = ^tail_data_i;

  assign ld_ready_o   = en_i & (state_q == IDLE_S);
  assign data_valid_o = en_i & (state_q == ISSUE_S);
  assign tail_yumi_o  = en_i & tail_valid_i & (tail_cnt_q < len_q)
                      & ((state_q == ISSUE_S) | (state_q == DRAIN_S));
  assign done_o       = en_i & (state_q == DONE_S);
  assign busy_o       = (state_q != IDLE_S);
  assign data_o       = (state_q == ISSUE_S) ? rdata : '0;

  assign ld_fire  = ld_valid_i & ld_ready_o;
  assign iss_fire = data_valid_o & data_ready_i;

  feeder_buf #(
    .width_p (width_p),
    .depth_p (depth_p),
    .addr_w_p(AW)
  ) u_buf (
    .clk_i  (clk_i),
    .we_i   (ld_fire),
    .waddr_i(wr_cnt_q[AW-1:0]),
    .wdata_i(ld_data_i),
    .raddr_i(rd_cnt_q[AW-1:0]),
    .rdata_o(rdata)
  );

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    wr_cnt_d   = wr_cnt_q;
    rd_cnt_d   = rd_cnt_q;
    tail_cnt_d = tail_cnt_q;
    skew_cnt_d = skew_cnt_q;

    if (tail_yumi_o) begin
      tail_cnt_d = tail_cnt_q + CW'(1);
    end

    if (en_i) begin
      case (state_q)
        IDLE_S: begin
          if (ld_fire) begin
            wr_cnt_d = wr_cnt_q + CW'(1);
            if (ld_last_i || (wr_cnt_q == CW'(depth_p - 1))) begin
              len_d   = wr_cnt_q + CW'(1);
              state_d = ARMED_S;
            end
          end
        end
        ARMED_S: begin
          if (start_i) begin
            if (skew_p == 0) begin
              state_d = ISSUE_S;
            end else begin
              skew_cnt_d = SW'(skew_p);
              state_d    = SKEW_S;
            end
          end
        end
        SKEW_S: begin
          skew_cnt_d = skew_cnt_q - SW'(1);
          if (skew_cnt_q == SW'(1)) begin
            state_d = ISSUE_S;
          end
        end
        ISSUE_S: begin
          if (iss_fire) begin
            rd_cnt_d = rd_cnt_q + CW'(1);
            if (rd_cnt_q == len_q - CW'(1)) begin
              state_d = DRAIN_S;
            end
          end
        end
        // Looking at the next tail count lets done_o follow the final yumi.
        DRAIN_S: begin
          if (tail_cnt_d == len_q) begin
            state_d = DONE_S;
          end
        end
        DONE_S: begin
          len_d      = '0;
          wr_cnt_d   = '0;
          rd_cnt_d   = '0;
          tail_cnt_d = '0;
          skew_cnt_d = '0;
          state_d    = IDLE_S;
        end
        default: state_d = IDLE_S;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= IDLE_S;
      len_q      <= '0;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      tail_cnt_q <= '0;
      skew_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      tail_cnt_q <= tail_cnt_d;
      skew_cnt_q <= skew_cnt_d;
    end
  end

endmodule
